// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage miniRV pipeline: stalls,
// flushes and EX forwarding selects; handles load-use, taken branches,
// data-RAM wait states and the ebreak drain-and-halt sequence.
// Ports: clk_i/rst_n_i (async active-low); ID/EX/MEM/WB hazard inputs;
// ram_busy_i; pc/if_id/ex_mem/mem_wb stall and if_id/id_ex flush outputs;
// fwd_a_o/fwd_b_o (00 rf, 01 EX/MEM, 10 MEM/WB); halted_o.
// Optional: define PIPE_PERF_CNT_EN to add perf_cyc_o, perf_stall_o and
// perf_flush_o saturating 32-bit counters.
module pipe_hazard_ctrl #(
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter logic [1:0]  LOAD_WSEL    = 2'b01
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic [4:0] id_rs1_i,
  input  logic [4:0] id_rs2_i,
  input  logic       id_rs1_use_i,
  input  logic       id_rs2_use_i,
  input  logic       id_halt_i,
  input  logic [4:0] ex_rs1_i,
  input  logic [4:0] ex_rs2_i,
  input  logic [4:0] ex_wR_i,
  input  logic       ex_rf_we_i,
  input  logic [1:0] ex_rf_wsel_i,
  input  logic       ex_br_taken_i,
  input  logic [4:0] mem_wR_i,
  input  logic       mem_rf_we_i,
  input  logic [1:0] mem_rf_wsel_i,
  input  logic [4:0] wb_wR_i,
  input  logic       wb_rf_we_i,
  input  logic       ram_busy_i,
  output logic       pc_stall_o,
  output logic       if_id_stall_o,
  output logic       if_id_flush_o,
  output logic       id_ex_flush_o,
  output logic       ex_mem_stall_o,
  output logic       mem_wb_stall_o,
  output logic [1:0] fwd_a_o,
  output logic [1:0] fwd_b_o,
  output logic       halted_o
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [31:0] perf_cyc_o,
  output logic [31:0] perf_stall_o,
  output logic [31:0] perf_flush_o
`endif
);

  localparam int unsigned CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_MEM_WAIT = 2'd1,
    S_DRAIN    = 2'd2,
    S_HALT     = 2'd3
  } state_t;

  state_t        r_state, w_nstate;
  logic [CW-1:0] r_cnt, w_ncnt;

  logic w_pc_stall, w_if_id_stall, w_if_id_flush;
  logic w_id_ex_flush, w_ex_mem_stall, w_mem_wb_stall;
  logic w_load_use;

  // Loads are not forwarded from EX/MEM: their data only exists after MEM.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
    if (mem_rf_we_i && mem_wR_i != 5'd0 && mem_wR_i == rs &&
        mem_rf_wsel_i != LOAD_WSEL)
      return 2'b01;
    else if (wb_rf_we_i && wb_wR_i != 5'd0 && wb_wR_i == rs)
      return 2'b10;
    else
      return 2'b00;
  endfunction

  assign fwd_a_o = fwd_sel(ex_rs1_i);
  assign fwd_b_o = fwd_sel(ex_rs2_i);

  assign w_load_use = ex_rf_we_i && ex_rf_wsel_i == LOAD_WSEL &&
                      ex_wR_i != 5'd0 &&
                      ((id_rs1_use_i && id_rs1_i == ex_wR_i) ||
                       (id_rs2_use_i && id_rs2_i == ex_wR_i));

  always_comb begin
    w_nstate       = r_state;
    w_ncnt         = r_cnt;
    w_pc_stall     = 1'b0;
    w_if_id_stall  = 1'b0;
    w_if_id_flush  = 1'b0;
    w_id_ex_flush  = 1'b0;
    w_ex_mem_stall = 1'b0;
    w_mem_wb_stall = 1'b0;
    unique case (r_state)
      // MEM_WAIT releases into exactly the RUN decision, so both share it.
      S_RUN, S_MEM_WAIT: begin
        w_nstate = S_RUN;
        if (ram_busy_i) begin
          w_pc_stall     = 1'b1;
          w_if_id_stall  = 1'b1;
          w_ex_mem_stall = 1'b1;
          w_mem_wb_stall = 1'b1;
          w_nstate       = S_MEM_WAIT;
        end else if (ex_br_taken_i) begin
          w_if_id_flush = 1'b1;
          w_id_ex_flush = 1'b1;
        end else if (id_halt_i) begin
          w_pc_stall    = 1'b1;
          w_if_id_stall = 1'b1;
          w_id_ex_flush = 1'b1;
          w_ncnt        = '0;
          w_nstate      = S_DRAIN;
        end else if (w_load_use) begin
          w_pc_stall    = 1'b1;
          w_if_id_stall = 1'b1;
          w_id_ex_flush = 1'b1;
        end
      end
      S_DRAIN: begin
        w_pc_stall    = 1'b1;
        w_if_id_stall = 1'b1;
        w_id_ex_flush = 1'b1;
        if (ram_busy_i) begin
          w_ex_mem_stall = 1'b1;
          w_mem_wb_stall = 1'b1;
        end else if (r_cnt == CNT_LAST) begin
          w_nstate = S_HALT;
        end else begin
          w_ncnt = r_cnt + 1'b1;
        end
      end
      S_HALT: begin
        w_pc_stall    = 1'b1;
        w_if_id_stall = 1'b1;
        w_id_ex_flush = 1'b1;
      end
      default: w_nstate = S_RUN;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= S_RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_nstate;
      r_cnt   <= w_ncnt;
    end
  end

  assign pc_stall_o     = w_pc_stall;
  assign if_id_stall_o  = w_if_id_stall;
  assign if_id_flush_o  = w_if_id_flush;
  assign id_ex_flush_o  = w_id_ex_flush;
  assign ex_mem_stall_o = w_ex_mem_stall;
  assign mem_wb_stall_o = w_mem_wb_stall;
  assign halted_o       = (r_state == S_HALT);

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] r_perf_cyc, r_perf_stall, r_perf_flush;
  logic        w_run_like;

  assign w_run_like = (r_state == S_RUN) || (r_state == S_MEM_WAIT);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_perf_cyc   <= '0;
      r_perf_stall <= '0;
      r_perf_flush <= '0;
    end else begin
      if (r_state != S_HALT && r_perf_cyc != 32'hFFFF_FFFF)
        r_perf_cyc <= r_perf_cyc + 32'd1;
      if (w_run_like && w_pc_stall && r_perf_stall != 32'hFFFF_FFFF)
        r_perf_stall <= r_perf_stall + 32'd1;
      if (w_if_id_flush && r_perf_flush != 32'hFFFF_FFFF)
        r_perf_flush <= r_perf_flush + 32'd1;
    end
  end

  assign perf_cyc_o   = r_perf_cyc;
  assign perf_stall_o = r_perf_stall;
  assign perf_flush_o = r_perf_flush;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl.
// Control vector order: {pc_st, ifid_st, ifid_fl, idex_fl, exmem_st, memwb_st}.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_wR, mem_wR, wb_wR;
  logic       id_rs1_use, id_rs2_use, id_halt;
  logic       ex_rf_we, ex_br_taken, mem_rf_we, wb_rf_we, ram_busy;
  logic [1:0] ex_rf_wsel, mem_rf_wsel;
  logic       pc_stall, if_id_stall, if_id_flush, id_ex_flush;
  logic       ex_mem_stall, mem_wb_stall, halted;
  logic [1:0] fwd_a, fwd_b;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0] perf_cyc, perf_stall, perf_flush;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .id_rs1_i       (id_rs1),
    .id_rs2_i       (id_rs2),
    .id_rs1_use_i   (id_rs1_use),
    .id_rs2_use_i   (id_rs2_use),
    .id_halt_i      (id_halt),
    .ex_rs1_i       (ex_rs1),
    .ex_rs2_i       (ex_rs2),
    .ex_wR_i        (ex_wR),
    .ex_rf_we_i     (ex_rf_we),
    .ex_rf_wsel_i   (ex_rf_wsel),
    .ex_br_taken_i  (ex_br_taken),
    .mem_wR_i       (mem_wR),
    .mem_rf_we_i    (mem_rf_we),
    .mem_rf_wsel_i  (mem_rf_wsel),
    .wb_wR_i        (wb_wR),
    .wb_rf_we_i     (wb_rf_we),
    .ram_busy_i     (ram_busy),
    .pc_stall_o     (pc_stall),
    .if_id_stall_o  (if_id_stall),
    .if_id_flush_o  (if_id_flush),
    .id_ex_flush_o  (id_ex_flush),
    .ex_mem_stall_o (ex_mem_stall),
    .mem_wb_stall_o (mem_wb_stall),
    .fwd_a_o        (fwd_a),
    .fwd_b_o        (fwd_b),
    .halted_o       (halted)
`ifdef PIPE_PERF_CNT_EN
    ,
    .perf_cyc_o     (perf_cyc),
    .perf_stall_o   (perf_stall),
    .perf_flush_o   (perf_flush)
`endif
  );

  wire [5:0] ctl = {pc_stall, if_id_stall, if_id_flush,
                    id_ex_flush, ex_mem_stall, mem_wb_stall};

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    id_rs1 = 0; id_rs2 = 0; id_rs1_use = 0; id_rs2_use = 0;
    id_halt = 0; ex_rs1 = 0; ex_rs2 = 0; ex_wR = 0;
    ex_rf_we = 0; ex_rf_wsel = 0; ex_br_taken = 0;
    mem_wR = 0; mem_rf_we = 0; mem_rf_wsel = 0;
    wb_wR = 0; wb_rf_we = 0; ram_busy = 0;
  endtask

  task automatic load_use5();
    ex_wR = 5; ex_rf_we = 1; ex_rf_wsel = 2'b01;
    id_rs1 = 5; id_rs1_use = 1;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    clr();
    rst_n = 0;
    tick(); tick();
    #1;
    chk("rst_ctl", 32'(ctl), 32'b000000);
    chk("rst_fwd", 32'({fwd_a, fwd_b}), 32'b0000);
    chk("rst_halt", 32'(halted), 32'd0);
    rst_n = 1;
    tick();

    // load-use: one bubble, then consumer forwards from MEM/WB
    load_use5(); #1;
    chk("lu_ctl", 32'(ctl), 32'b110100);
    tick();
    clr();
    id_rs1 = 5; id_rs1_use = 1;
    mem_wR = 5; mem_rf_we = 1; mem_rf_wsel = 2'b01; #1;
    chk("lu_bubble_ctl", 32'(ctl), 32'b000000);
    tick();
    clr();
    ex_rs1 = 5; wb_wR = 5; wb_rf_we = 1; #1;
    chk("lu_fwd_a", 32'(fwd_a), 32'b10);
    chk("lu_next_ctl", 32'(ctl), 32'b000000);
    mem_wR = 5; mem_rf_we = 1; mem_rf_wsel = 2'b01; #1;
    chk("no_fwd_load_mem", 32'(fwd_a), 32'b10);
    // load-use via rs2 only
    clr(); ex_wR = 9; ex_rf_we = 1; ex_rf_wsel = 2'b01;
    id_rs2 = 9; id_rs2_use = 1; #1;
    chk("lu_rs2_ctl", 32'(ctl), 32'b110100);
    id_rs2_use = 0; #1;
    chk("lu_unused_ctl", 32'(ctl), 32'b000000);
    tick();

    // forwarding priority and x0
    clr();
    ex_rs2 = 7; mem_wR = 7; mem_rf_we = 1; wb_wR = 7; wb_rf_we = 1; #1;
    chk("fwd_b_mem", 32'(fwd_b), 32'b01);
    chk("fwd_a_none", 32'(fwd_a), 32'b00);
    mem_rf_we = 0; #1;
    chk("fwd_b_wb", 32'(fwd_b), 32'b10);
    ex_rs2 = 0; mem_wR = 0; mem_rf_we = 1; wb_wR = 0; #1;
    chk("fwd_b_x0", 32'(fwd_b), 32'b00);
    tick();

    // branch with wrong-path load-use and halt
    clr(); load_use5(); ex_br_taken = 1; id_halt = 1; #1;
    chk("br_lu_ctl", 32'(ctl), 32'b001100);
    tick();
    clr(); #1;
    chk("br_after_ctl", 32'(ctl), 32'b000000);

    // RAM busy 3 cycles while a branch is held
    for (int i = 0; i < 3; i++) begin
      clr(); ram_busy = 1; ex_br_taken = 1; id_halt = 1; #1;
      chk($sformatf("busy%0d_ctl", i), 32'(ctl), 32'b110011);
      tick();
    end
    clr(); ex_br_taken = 1; #1;
    chk("busy_rel_ctl", 32'(ctl), 32'b001100);
    tick();
    clr(); #1;
    chk("busy_run_ctl", 32'(ctl), 32'b000000);

    // halt: 3 counted DRAIN cycles, one busy cycle freezes the counter
    id_halt = 1; #1;
    chk("halt_req_ctl", 32'(ctl), 32'b110100);
    tick();
    clr(); #1;
    chk("drain0_ctl", 32'(ctl), 32'b110100);
    tick();
    ram_busy = 1; #1;
    chk("drain_busy_ctl", 32'(ctl), 32'b110111);
    tick();
    ram_busy = 0; #1;
    chk("drain1_ctl", 32'(ctl), 32'b110100);
    chk("drain1_halt", 32'(halted), 32'd0);
    tick(); #1;
    chk("drain2_halt", 32'(halted), 32'd0);
    tick(); #1;
    chk("halted", 32'(halted), 32'd1);
    chk("halt_ctl", 32'(ctl), 32'b110100);
    ex_br_taken = 1; tick(); tick(); #1;
    chk("halt_hold", 32'(halted), 32'd1);
    chk("halt_no_br", 32'(ctl), 32'b110100);
    #1 rst_n = 0; #1;
    chk("halt_rst", 32'(halted), 32'd0);
    tick(); rst_n = 1; clr(); tick(); #1;
    chk("post_rst_ctl", 32'(ctl), 32'b000000);
    ram_busy = 1; #1;
    chk("post_rst_busy", 32'(ctl), 32'b110011);
    tick();
    // reset while in MEM_WAIT
    #1 rst_n = 0; clr(); #1;
    chk("mw_rst_ctl", 32'(ctl), 32'b000000);
    tick(); rst_n = 1;

`ifdef PIPE_PERF_CNT_EN
    for (int i = 0; i < 10; i++) begin
      clr();
      if (i == 2) load_use5();
      if (i == 5) ex_br_taken = 1;
      tick();
    end
    #1;
    chk("perf_cyc", perf_cyc, 32'd10);
    chk("perf_stall", perf_stall, 32'd1);
    chk("perf_flush", perf_flush, 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
